// File: rtl/vga_pixel_path.sv
// vga_pixel_path
// Downstream pixel stage of the VGA driver. It registers the incoming syncs and
// BRAM coordinates, tracks the horizontal and vertical active-video windows
// from the sync edges, addresses the image BRAM, and drives the VGA pins with
// colour blanked outside the window. Syncs and RGB leave together, three
// clocks after the inputs.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low
//   HSYNC/VSYNC  active-low sync pulses from the timing stages
//   HPIXEL       BRAM column index (7 bits)
//   VPIXEL       BRAM row index (7 bits)
//   bram_data    {R,G,B} 4:4:4 word, valid one clock after bram_addr
//   bram_addr    registered {VPIXEL,HPIXEL} read address
//   VGA_R/G/B    colour, 0 while blanked
//   VGA_HSYNC/VGA_VSYNC  syncs realigned to RGB
//   frame_start  one-clock pulse with the first active pixel of each frame
module vga_pixel_path #(
  parameter int H_BP_CYCLES     = 192,
  parameter int H_ACTIVE_CYCLES = 2560,
  parameter int V_BP_CYCLES     = 92800,
  parameter int V_ACTIVE_CYCLES = 1536000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic [6:0]  HPIXEL,
  input  logic [6:0]  VPIXEL,
  input  logic [11:0] bram_data,
  output logic [13:0] bram_addr,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC,
  output logic        frame_start
);

  localparam logic [11:0] H_BP_LAST     = 12'(H_BP_CYCLES - 1);
  localparam logic [11:0] H_ACTIVE_LAST = 12'(H_ACTIVE_CYCLES - 1);
  localparam logic [23:0] V_BP_LAST     = 24'(V_BP_CYCLES - 1);
  localparam logic [23:0] V_ACTIVE_LAST = 24'(V_ACTIVE_CYCLES - 1);

  typedef enum logic [1:0] {H_SYNC, H_BP, H_ACTIVE, H_FP} h_state_t;
  typedef enum logic [1:0] {V_SYNC, V_BP, V_ACTIVE, V_FP} v_state_t;

  logic       s1_hsync, s1_vsync, hsync_d, vsync_d;
  logic [6:0] s1_hpixel, s1_vpixel;
  logic       h_fall, h_rise, v_fall, v_rise;

  h_state_t    h_state, h_next;
  v_state_t    v_state, v_next;
  logic [11:0] h_cnt, h_cnt_next;
  logic [23:0] v_cnt, v_cnt_next;

  logic de, fs_arm, fs_now, v_enter_active;
  logic de_d, hsync_s2, vsync_s2, fs_d;

  // Stage 1 plus the delayed sync copies used for edge detection. Syncs reset
  // high so no edge is seen coming out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
      hsync_d   <= 1'b1;
      vsync_d   <= 1'b1;
      s1_hpixel <= '0;
      s1_vpixel <= '0;
      bram_addr <= '0;
    end else begin
      s1_hsync  <= HSYNC;
      s1_vsync  <= VSYNC;
      hsync_d   <= s1_hsync;
      vsync_d   <= s1_vsync;
      s1_hpixel <= HPIXEL;
      s1_vpixel <= VPIXEL;
      bram_addr <= {s1_vpixel, s1_hpixel};
    end
  end

  assign h_fall = hsync_d & ~s1_hsync;
  assign h_rise = ~hsync_d & s1_hsync;
  assign v_fall = vsync_d & ~s1_vsync;
  assign v_rise = ~vsync_d & s1_vsync;

  // State and counter registers for both axes. Reset parks them in the
  // front porch, i.e. unlocked until a full sync pulse has been seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_state <= H_FP;
      v_state <= V_FP;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      h_state <= h_next;
      v_state <= v_next;
      h_cnt   <= h_cnt_next;
      v_cnt   <= v_cnt_next;
    end
  end

  // Horizontal window tracker. A falling edge always wins so a stray sync
  // resynchronises the line; the counter saturates instead of wrapping.
  always_comb begin
    h_next     = h_state;
    h_cnt_next = (h_cnt == 12'hFFF) ? h_cnt : h_cnt + 12'd1;
    if (h_fall) begin
      h_next     = H_SYNC;
      h_cnt_next = '0;
    end else begin
      case (h_state)
        H_SYNC:   if (h_rise) begin
                    h_next     = H_BP;
                    h_cnt_next = '0;
                  end
        H_BP:     if (h_cnt == H_BP_LAST) begin
                    h_next     = H_ACTIVE;
                    h_cnt_next = '0;
                  end
        H_ACTIVE: if (h_cnt == H_ACTIVE_LAST) begin
                    h_next     = H_FP;
                    h_cnt_next = '0;
                  end
        default:  ;
      endcase
    end
  end

  // Vertical window tracker, same rules on VSYNC with a 24-bit counter.
  always_comb begin
    v_next     = v_state;
    v_cnt_next = (v_cnt == 24'hFF_FFFF) ? v_cnt : v_cnt + 24'd1;
    if (v_fall) begin
      v_next     = V_SYNC;
      v_cnt_next = '0;
    end else begin
      case (v_state)
        V_SYNC:   if (v_rise) begin
                    v_next     = V_BP;
                    v_cnt_next = '0;
                  end
        V_BP:     if (v_cnt == V_BP_LAST) begin
                    v_next     = V_ACTIVE;
                    v_cnt_next = '0;
                  end
        V_ACTIVE: if (v_cnt == V_ACTIVE_LAST) begin
                    v_next     = V_FP;
                    v_cnt_next = '0;
                  end
        default:  ;
      endcase
    end
  end

  assign de             = (h_state == H_ACTIVE) && (v_state == V_ACTIVE);
  assign v_enter_active = (v_state == V_BP) && (v_next == V_ACTIVE);
  assign fs_now         = de & fs_arm;

  // fs_arm is raised when the frame opens and dropped by the first active
  // pixel, so frame_start fires once per frame even though de toggles per line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_arm <= 1'b0;
    end else if (v_enter_active) begin
      fs_arm <= 1'b1;
    end else if (fs_now || (v_state != V_ACTIVE)) begin
      fs_arm <= 1'b0;
    end
  end

  // Stages 2 and 3: delay de and syncs so colour lines up with the BRAM word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_d        <= 1'b0;
      hsync_s2    <= 1'b1;
      vsync_s2    <= 1'b1;
      fs_d        <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HSYNC   <= 1'b1;
      VGA_VSYNC   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      de_d                  <= de;
      hsync_s2              <= s1_hsync;
      vsync_s2              <= s1_vsync;
      fs_d                  <= fs_now;
      {VGA_R, VGA_G, VGA_B} <= de_d ? bram_data : 12'h000;
      VGA_HSYNC             <= hsync_s2;
      VGA_VSYNC             <= vsync_s2;
      frame_start           <= fs_d;
    end
  end

endmodule

// File: tb/tb_vga_pixel_path.sv
// Testbench for vga_pixel_path using a shrunken timing: 20-clock lines with
// HSYNC low for 3, 8-line frames with VSYNC low for 2 lines, back porch 4 clk
// horizontally and 2 lines vertically, 8 active clocks on 3 active lines.
module tb_vga_pixel_path;

  localparam int HBP    = 4;
  localparam int HACT   = 8;
  localparam int VBP    = 40;
  localparam int VACT   = 60;
  localparam int LINE   = 20;
  localparam int HLOW   = 3;
  localparam int FLINES = 8;
  localparam int VLOWL  = 2;
  localparam int FRAME  = LINE * FLINES;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        HSYNC = 1'b1;
  logic        VSYNC = 1'b1;
  logic [6:0]  HPIXEL = '0;
  logic [6:0]  VPIXEL = '0;
  logic [11:0] bram_data = '0;
  logic [13:0] bram_addr;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HSYNC, VGA_VSYNC, frame_start;

  int checks = 0;
  int fails  = 0;

  // Stimulus position and expectation history (index 0 = newest sample).
  int          p;
  int          valid_from;
  int          inj_frame = -1;
  int          cur_fr;
  int          nz_cnt[0:7];
  int          fs_cnt[0:7];
  logic        hs_q[3], vs_q[3], act_q[3], fs_q[3];
  logic [13:0] addr_q[3];
  logic [28:0] exp_vec;
  wire  [28:0] obs_vec = {VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC, frame_start, bram_addr};

  vga_pixel_path #(
    .H_BP_CYCLES(HBP), .H_ACTIVE_CYCLES(HACT),
    .V_BP_CYCLES(VBP), .V_ACTIVE_CYCLES(VACT)
  ) dut (
    .clk(clk), .reset(reset), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .HPIXEL(HPIXEL), .VPIXEL(VPIXEL), .bram_data(bram_data),
    .bram_addr(bram_addr), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Seed the expectation history with the steady inputs currently applied.
  task automatic init_history(input logic idle_addr);
    for (int i = 0; i < 3; i++) begin
      hs_q[i]   = HSYNC;
      vs_q[i]   = VSYNC;
      act_q[i]  = 1'b0;
      fs_q[i]   = 1'b0;
      addr_q[i] = idle_addr ? 14'h0 : {VPIXEL, HPIXEL};
    end
  endtask

  // Drives one clock of the shrunken raster at position p and works out the
  // expected output vector for the clock that follows. Outputs reflect the
  // sample two edges back; bram_addr the sample one edge back.
  task automatic applyStimulus();
    int hp, ln, fr;
    logic hs, vs, act, fs;
    logic [11:0] dat;
    hp  = p % LINE;
    ln  = (p / LINE) % FLINES;
    fr  = p / FRAME;
    hs  = (hp >= HLOW);
    vs  = (ln >= VLOWL);
    if (fr == inj_frame && ln == 5 && hp >= 11) hs = 1'b0;
    act = (fr >= valid_from) && (ln >= 4) && (ln <= 6) && (hp >= 8) && (hp <= 15)
          && !(fr == inj_frame && ln == 5 && hp >= 12);
    fs  = (fr >= valid_from) && (ln == 4) && (hp == 8);
    dat = (fr >= 2) ? {4'(p), 4'(p >> 4), 4'hA} : 12'hF0A;
    HSYNC = hs; VSYNC = vs; HPIXEL = 7'(p); VPIXEL = 7'(p >> 7); bram_data = dat;
    for (int i = 2; i > 0; i--) begin
      hs_q[i] = hs_q[i-1]; vs_q[i] = vs_q[i-1]; act_q[i] = act_q[i-1];
      fs_q[i] = fs_q[i-1]; addr_q[i] = addr_q[i-1];
    end
    if (reset) begin
      hs_q[0] = hs; vs_q[0] = vs; act_q[0] = act; fs_q[0] = fs; addr_q[0] = {VPIXEL, HPIXEL};
    end else begin
      hs_q[0] = 1'b1; vs_q[0] = 1'b1; act_q[0] = 1'b0; fs_q[0] = 1'b0; addr_q[0] = 14'h0;
    end
    @(posedge clk); #1;
    cur_fr  = fr;
    exp_vec = {act_q[2] ? dat : 12'h000, hs_q[2], vs_q[2], fs_q[2], addr_q[1]};
    p++;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++; if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin fails++; $display("[TB] FAIL reset_rgb: got %h expected 000", {VGA_R, VGA_G, VGA_B}); end
    checks++; if (VGA_HSYNC !== 1'b1) begin fails++; $display("[TB] FAIL reset_hsync: got %b expected 1", VGA_HSYNC); end
    checks++; if (VGA_VSYNC !== 1'b1) begin fails++; $display("[TB] FAIL reset_vsync: got %b expected 1", VGA_VSYNC); end
    checks++; if (bram_addr !== 14'h0) begin fails++; $display("[TB] FAIL reset_addr: got %h expected 0000", bram_addr); end
    checks++; if (frame_start !== 1'b0) begin fails++; $display("[TB] FAIL reset_fs: got %b expected 0", frame_start); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (obs_vec !== {12'h000, 1'b1, 1'b1, 1'b0, 14'h0}) begin fails++; $display("[TB] FAIL post_reset_idle: got %h expected %h", obs_vec, {12'h000, 1'b1, 1'b1, 1'b0, 14'h0}); end
  endtask

  task automatic test_bram_addr();
    HPIXEL = 7'h05; VPIXEL = 7'h2A;
    @(posedge clk); #1;
    checks++; if (bram_addr !== 14'h0000) begin fails++; $display("[TB] FAIL addr_early: got %h expected 0000", bram_addr); end
    @(posedge clk); #1;
    checks++; if (bram_addr !== 14'h1505) begin fails++; $display("[TB] FAIL addr_latency: got %h expected 1505", bram_addr); end
    checks++; if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin fails++; $display("[TB] FAIL addr_blank: got %h expected 000", {VGA_R, VGA_G, VGA_B}); end
  endtask

  task automatic test_frames();
    int first_nz;
    first_nz = -1;
    p = 2 * LINE; valid_from = 1; inj_frame = -1;
    init_history(1'b0);
    while (p < 3 * FRAME) begin
      applyStimulus();
      checks++;
      if (obs_vec !== exp_vec) begin fails++; $display("[TB] FAIL frames p=%0d: got %h expected %h", p - 1, obs_vec, exp_vec); end
      if (obs_vec[28:17] != 12'h000) begin
        nz_cnt[cur_fr]++;
        if (first_nz < 0 && cur_fr == 1) first_nz = p - 1;
      end
      if (obs_vec[14]) fs_cnt[cur_fr]++;
    end
    checks++; if (nz_cnt[0] !== 0) begin fails++; $display("[TB] FAIL first_frame_blank: got %0d expected 0", nz_cnt[0]); end
    checks++; if (nz_cnt[1] !== 3 * HACT) begin fails++; $display("[TB] FAIL frame1_active: got %0d expected %0d", nz_cnt[1], 3 * HACT); end
    checks++; if (nz_cnt[2] !== 3 * HACT) begin fails++; $display("[TB] FAIL frame2_active: got %0d expected %0d", nz_cnt[2], 3 * HACT); end
    checks++; if (fs_cnt[0] !== 0) begin fails++; $display("[TB] FAIL frame0_fs: got %0d expected 0", fs_cnt[0]); end
    checks++; if (fs_cnt[1] !== 1) begin fails++; $display("[TB] FAIL frame1_fs: got %0d expected 1", fs_cnt[1]); end
    checks++; if (fs_cnt[2] !== 1) begin fails++; $display("[TB] FAIL frame2_fs: got %0d expected 1", fs_cnt[2]); end
    checks++;
    if (first_nz - ((first_nz / LINE) * LINE + HLOW) + 1 !== HBP + 1 + 3) begin
      fails++; $display("[TB] FAIL first_pixel_delay: got %0d expected %0d", first_nz - ((first_nz / LINE) * LINE + HLOW) + 1, HBP + 4);
    end
  endtask

  task automatic test_early_hsync();
    inj_frame = 3;
    while (p < 4 * FRAME) begin
      applyStimulus();
      checks++;
      if (obs_vec !== exp_vec) begin fails++; $display("[TB] FAIL early_hsync p=%0d: got %h expected %h", p - 1, obs_vec, exp_vec); end
      if (obs_vec[28:17] != 12'h000) nz_cnt[cur_fr]++;
    end
    inj_frame = -1;
    checks++; if (nz_cnt[3] !== 2 * HACT + 4) begin fails++; $display("[TB] FAIL early_hsync_count: got %0d expected %0d", nz_cnt[3], 2 * HACT + 4); end
  endtask

  task automatic test_reset_midline();
    int post_nz;
    post_nz = 0;
    while (p < 4 * FRAME + 5 * LINE + 12) begin
      applyStimulus();
      checks++;
      if (obs_vec !== exp_vec) begin fails++; $display("[TB] FAIL pre_reset p=%0d: got %h expected %h", p - 1, obs_vec, exp_vec); end
    end
    #1 reset = 1'b0;
    #1;
    checks++; if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin fails++; $display("[TB] FAIL midline_rgb: got %h expected 000", {VGA_R, VGA_G, VGA_B}); end
    checks++; if ({VGA_HSYNC, VGA_VSYNC} !== 2'b11) begin fails++; $display("[TB] FAIL midline_syncs: got %b expected 11", {VGA_HSYNC, VGA_VSYNC}); end
    checks++; if (frame_start !== 1'b0) begin fails++; $display("[TB] FAIL midline_fs: got %b expected 0", frame_start); end
    init_history(1'b1);
    for (int i = 0; i < 2; i++) hs_q[i] = 1'b1;
    for (int i = 0; i < 3; i++) vs_q[i] = 1'b1;
    hs_q[2] = 1'b1;
    valid_from = 5;
    repeat (3) begin
      applyStimulus();
      checks++;
      if (obs_vec !== exp_vec) begin fails++; $display("[TB] FAIL in_reset p=%0d: got %h expected %h", p - 1, obs_vec, exp_vec); end
    end
    reset = 1'b1;
    while (p < 6 * FRAME) begin
      applyStimulus();
      checks++;
      if (obs_vec !== exp_vec) begin fails++; $display("[TB] FAIL after_reset p=%0d: got %h expected %h", p - 1, obs_vec, exp_vec); end
      if (obs_vec[28:17] != 12'h000) begin
        if (cur_fr == 4) post_nz++;
        else nz_cnt[cur_fr]++;
      end
      if (obs_vec[14]) fs_cnt[cur_fr]++;
    end
    checks++; if (post_nz !== 0) begin fails++; $display("[TB] FAIL reset_frame_blank: got %0d expected 0", post_nz); end
    checks++; if (nz_cnt[5] !== 3 * HACT) begin fails++; $display("[TB] FAIL relock_active: got %0d expected %0d", nz_cnt[5], 3 * HACT); end
    checks++; if (fs_cnt[5] !== 1) begin fails++; $display("[TB] FAIL relock_fs: got %0d expected 1", fs_cnt[5]); end
  endtask

  task automatic test_saturation();
    HSYNC = 1'b1; VSYNC = 1'b1;
    for (int c = 1; c <= 10000; c++) begin
      @(posedge clk); #1;
      if (c % 500 == 0) begin
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin fails++; $display("[TB] FAIL sat_rgb c=%0d: got %h expected 000", c, {VGA_R, VGA_G, VGA_B}); end
        checks++; if ($isunknown(obs_vec)) begin fails++; $display("[TB] FAIL sat_known c=%0d: got %h expected no X", c, obs_vec); end
      end
    end
    p = 7 * FRAME; valid_from = 7;
    init_history(1'b0);
    while (p < 8 * FRAME) begin
      applyStimulus();
      checks++;
      if (obs_vec !== exp_vec) begin fails++; $display("[TB] FAIL sat_recover p=%0d: got %h expected %h", p - 1, obs_vec, exp_vec); end
      if (obs_vec[28:17] != 12'h000) nz_cnt[cur_fr]++;
    end
    checks++; if (nz_cnt[7] !== 3 * HACT) begin fails++; $display("[TB] FAIL sat_recover_active: got %0d expected %0d", nz_cnt[7], 3 * HACT); end
  endtask

  // Scenario sequence; each task carries its own comparisons.
  initial begin
    for (int i = 0; i < 8; i++) begin nz_cnt[i] = 0; fs_cnt[i] = 0; end
    test_reset();
    test_bram_addr();
    test_frames();
    test_early_hsync();
    test_reset_midline();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_pixel_path.md
# vga_pixel_path

Downstream pixel stage of the VGA driver. Consumes the row index and VSYNC from the vertical timing stage, plus the column index and HSYNC from the horizontal timing stage. Tracks the active-video window on both axes from the sync edges, addresses the image BRAM, and blanks colour outside the window. Drives the VGA pins with syncs and RGB realigned to the BRAM read latency.

## Interface
- H_BP_CYCLES, 192: clocks from HSYNC rising edge to first active pixel.
- H_ACTIVE_CYCLES, 2560: active clocks per line (640 pixels × 4 clk).
- V_BP_CYCLES, 92800: clocks from VSYNC rising edge to first active line (29 lines × 3200).
- V_ACTIVE_CYCLES, 1536000: active clocks per frame (480 lines × 3200).
- clk  in  1  system clock, 100 MHz; all logic on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- HSYNC  in  1  horizontal sync, active-low pulse.
- VSYNC  in  1  vertical sync, active-low pulse.
- HPIXEL  in  7  BRAM column index 0..127.
- VPIXEL  in  7  BRAM row index 0..95.
- bram_data  in  12  RGB 4:4:4 word {R,G,B}, valid 1 clk after bram_addr.
- bram_addr  out  14  {VPIXEL,HPIXEL} read address.
- VGA_R, VGA_G, VGA_B  out  4 each  colour; 0 when blanked.
- VGA_HSYNC, VGA_VSYNC  out  1 each  syncs delayed to match RGB.
- frame_start  out  1  one-clk pulse with the first active pixel of each frame.

## Operation
- Stage 1 registers HSYNC, VSYNC, HPIXEL and VPIXEL (s1_*).
  - bram_addr = {s1_VPIXEL, s1_HPIXEL}, registered.
- Edge detect runs on the s1 syncs against their 1-clk-delayed copies.
- Horizontal FSM, states H_SYNC, H_BP, H_ACTIVE, H_FP, with its own counter (12 bits minimum):
  - HSYNC falling edge in any state → H_SYNC.
  - H_SYNC → H_BP on rising edge; counter cleared.
  - H_BP → H_ACTIVE when counter = H_BP_CYCLES-1.
  - H_ACTIVE → H_FP when counter = H_ACTIVE_CYCLES-1.
  - H_FP holds until the next falling edge.
- Vertical FSM, states V_SYNC, V_BP, V_ACTIVE, V_FP, counter 24 bits. It uses identical rules with VSYNC, V_BP_CYCLES and V_ACTIVE_CYCLES.
- de = (h_state==H_ACTIVE) & (v_state==V_ACTIVE).
- Pipeline:
  - Stage 2 delays de and the syncs.
  - Stage 3 registers RGB = de_d ? bram_data : 12'h000, and registers VGA_HSYNC and VGA_VSYNC.
- frame_start is 1 at stage 3 on the first de=1 clock after the V_BP→V_ACTIVE transition. It is 0 otherwise.
- Counters saturate; they never wrap. A sync edge arriving mid-count resynchronises the FSM per the rules above. No error flag.

## Timing
- Reset (reset=0):
  - Both FSMs go to the FP state (unlocked); counters 0.
  - All pipeline registers 0, except sync registers = 1.
  - Outputs: RGB 0, VGA_HSYNC 1, VGA_VSYNC 1, bram_addr 0, frame_start 0.
- After reset release, RGB stays 0 until a VSYNC falling→rising sequence and then the V_BP count have completed. The first frame after reset is fully blank unless reset is released before VSYNC falls.
- Input→output latency is 3 clk for HSYNC, VSYNC and the de-to-RGB path.
- bram_addr appears 2 clk after its inputs; bram_data is sampled 1 clk later.
- Active pixel window at the inputs:
  - Starts H_BP_CYCLES+1 clk after the HSYNC rising edge.
  - Lasts exactly H_ACTIVE_CYCLES clk.
  - Appears at the outputs 3 clk later.
- Simultaneous H and V transitions are independent; de is their AND, evaluated the same clock.
- Asserting reset mid-line blanks RGB and forces the syncs high asynchronously in the same cycle.

## Test plan
- Reset, then drive 640×480 timing (HSYNC every 3200 clk, low 384; VSYNC low 6400 clk every 1,667,200) with bram_data=12'hF0A → RGB 0 for the first frame; second frame RGB = F,0,A for exactly 2560 clk per line on 480 lines; frame_start single pulse per frame.
- Check alignment: VGA_HSYNC/VGA_VSYNC equal the inputs delayed 3 clk; first RGB≠0 occurs 192+1+3 clk after the HSYNC rising edge.
- Drive HPIXEL=7'h05, VPIXEL=7'h2A → bram_addr=14'h1505 two clk later; bram_data change after 1 clk shows on RGB on the next clk.
- Inject an early HSYNC falling edge mid-H_ACTIVE → RGB 0 from 3 clk later; the next line is normal.
- Assert reset=0 mid-active-line → outputs immediately RGB 0, syncs 1, frame_start 0; after release, no RGB until a full VSYNC cycle plus V_BP.
- Hold HSYNC high for 10,000 clk → counters saturate; stays in H_FP with RGB 0 and no X on outputs.
